// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encodings, FSM state enumeration and state width.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_abs.sv
// Conditional two's-complement negation of a pair of W-bit values.
// wide=0: x and y are negated independently (operand magnitudes, or
//         quotient/remainder sign restore).
// wide=1: {x,y} is negated as one 2W-bit value (product sign restore).
module muldiv_abs #(
  parameter int W = 32
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         neg_x,
  input  logic         neg_y,
  input  logic         wide,
  output logic [W-1:0] x_out,
  output logic [W-1:0] y_out
);

  logic [2*W-1:0] joint;
  logic [2*W-1:0] joint_neg;

  // Select independent or joint negation.
  always_comb begin
    x_out     = x;
    y_out     = y;
    joint     = {x, y};
    joint_neg = -joint;
    if (wide) begin
      if (neg_x) begin
        {x_out, y_out} = joint_neg;
      end
    end else begin
      if (neg_x) x_out = -x;
      if (neg_y) y_out = -y;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Radix-2 iterative multiply/divide unit (MULT, MULTU, DIV, DIVU).
// One shift-add (multiply) or restoring shift-subtract (divide) step per
// RUN cycle; operands are converted to magnitudes on accept and the sign
// is restored on the final step. Unsigned magnitudes of WIDTH bits cover
// the most-negative operand (its magnitude 2^(WIDTH-1) is representable).
// Optional build macro MULDIV_FAST_MUL_EN: multiplies complete through a
// single-cycle combinational product, going IDLE->DONE directly.
// Handshake: a start in IDLE without cancel is accepted on the rising edge;
// done pulses for one cycle when hi/lo carry the new result; stall holds
// the pipeline from the request cycle until (not including) the DONE cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               cancel,
  output logic               busy,
  output logic               stall,
  output logic               done,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic [STATE_W-1:0] state_dbg
);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               div_q, sign_a, sign_b, div_zero;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   p_hi, p_lo;
  logic [WIDTH-1:0]   step_hi, step_lo;
  logic [WIDTH:0]     mul_sum, div_shift;
  logic               div_ge;

  logic               in_div, in_signed, in_neg_a, in_neg_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               accept, fast_accept, last_step, load_result;
  logic [2*WIDTH-1:0] fast_prod;

  logic [WIDTH-1:0]   out_x, out_y, res_hi, res_lo;
  logic               out_neg_x, out_neg_y, out_wide;

  assign in_div    = (op == OP_DIV) || (op == OP_DIVU);
  assign in_signed = (op == OP_MULT) || (op == OP_DIV);
  assign in_neg_a  = in_signed & a[WIDTH-1];
  assign in_neg_b  = in_signed & b[WIDTH-1];

  assign accept    = (state == ST_IDLE) & start & ~cancel;
  assign last_step = (state == ST_RUN) & ~cancel & (cnt == CNT_W'(1));

  muldiv_abs #(.W(WIDTH)) u_abs_in (
    .x     (a),
    .y     (b),
    .neg_x (in_neg_a),
    .neg_y (in_neg_b),
    .wide  (1'b0),
    .x_out (mag_a),
    .y_out (mag_b)
  );

`ifdef MULDIV_FAST_MUL_EN
  assign fast_accept = accept & ~in_div;
  assign fast_prod   = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
`else
  assign fast_accept = 1'b0;
  assign fast_prod   = '0;
`endif

  assign load_result = last_step | fast_accept;

  // One radix-2 step: shift-add multiply or restoring shift-subtract divide.
  always_comb begin
    step_hi   = p_hi;
    step_lo   = p_lo;
    mul_sum   = {1'b0, p_hi} + (p_lo[0] ? {1'b0, opnd} : '0);
    div_shift = {p_hi, p_lo[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd});
    if (div_q) begin
      // The true difference is below the divisor, so WIDTH bits suffice.
      step_hi = div_ge ? (div_shift[WIDTH-1:0] - opnd) : div_shift[WIDTH-1:0];
      step_lo = {p_lo[WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], p_lo[WIDTH-1:1]};
    end
  end

  // Route the finished magnitude (iterative or fast) into sign restore.
  always_comb begin
    out_x     = step_hi;
    out_y     = step_lo;
    out_wide  = ~div_q;
    out_neg_x = div_q ? sign_a : (sign_a ^ sign_b);
    out_neg_y = sign_a ^ sign_b;
    if (fast_accept) begin
      out_x     = fast_prod[2*WIDTH-1:WIDTH];
      out_y     = fast_prod[WIDTH-1:0];
      out_wide  = 1'b1;
      out_neg_x = in_neg_a ^ in_neg_b;
      out_neg_y = in_neg_a ^ in_neg_b;
    end
  end

  muldiv_abs #(.W(WIDTH)) u_abs_out (
    .x     (out_x),
    .y     (out_y),
    .neg_x (out_neg_x),
    .neg_y (out_neg_y),
    .wide  (out_wide),
    .x_out (res_hi),
    .y_out (res_lo)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // FSM next state; cancel wins over everything outside IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = fast_accept ? ST_DONE : ST_RUN;
      ST_RUN: begin
        if (cancel)         state_nxt = ST_IDLE;
        else if (last_step) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy      = (state == ST_RUN);
  assign stall     = rst & ((accept & ~fast_accept) | (state == ST_RUN));
  assign done      = (state == ST_DONE) & ~cancel;
  assign state_dbg = state;

  // Datapath: latch operands on accept, step in RUN, publish on completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      div_q    <= 1'b0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      div_zero <= 1'b0;
      opnd     <= '0;
      p_hi     <= '0;
      p_lo     <= '0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      if (accept) begin
        cnt      <= CNT_W'(WIDTH);
        div_q    <= in_div;
        sign_a   <= in_neg_a;
        sign_b   <= in_neg_b;
        div_zero <= in_div & (b == '0);
        opnd     <= in_div ? mag_b : mag_a;
        p_hi     <= '0;
        p_lo     <= in_div ? mag_a : mag_b;
      end else if ((state == ST_RUN) && !cancel) begin
        cnt  <= cnt - CNT_W'(1);
        p_hi <= step_hi;
        p_lo <= step_lo;
      end
      if (load_result) begin
        hi <= res_hi;
        lo <= (div_zero & ~fast_accept) ? '1 : res_lo;
      end
    end
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand and HI/LO width; legal values are even, 8..64.
REQ-002 Parameter CNT_W, default $clog2(WIDTH)+1, width of the iteration counter.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  request to begin an operation; sampled only in IDLE.
REQ-006 op  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 a  in  WIDTH  dividend / multiplicand (rs value).
REQ-008 b  in  WIDTH  divisor / multiplier (rt value).
REQ-009 cancel  in  1  pipeline flush; aborts any operation in progress.
REQ-010 busy  out  1  high while in RUN.
REQ-011 stall  out  1  pipeline hold request to the hazard unit.
REQ-012 done  out  1  one-cycle pulse; hi/lo hold a new result.
REQ-013 hi  out  WIDTH  high product half or remainder.
REQ-014 lo  out  WIDTH  low product half or quotient.

Function
REQ-015 FSM states: IDLE, RUN, DONE; IDLE->RUN on start&~cancel; RUN->DONE when the counter reaches 0; DONE->IDLE unconditionally.
REQ-016 On start acceptance, the block latches op, |a|, |b| and sign flags, and loads the counter with WIDTH.
REQ-017 RUN performs exactly one radix-2 step per cycle (shift-add for multiply, restoring shift-subtract for divide) and decrements the counter.
REQ-018 Latency: done is high exactly WIDTH+1 cycles after the start-accept edge.
REQ-019 stall = (state==IDLE & start & ~cancel) | (state==RUN); stall is low in DONE so the consumer advances in that cycle.
REQ-020 hi/lo update only on the RUN->DONE edge and otherwise hold their values.
REQ-021 Signed results: the product is negated if a[MSB]^b[MSB]; the quotient sign is a^b; the remainder takes the sign of a; the magnitude of the most-negative operand is handled in WIDTH+1 bits.
REQ-022 Divide by zero: lo = all ones, hi = a, and the full latency still applies.
REQ-023 start during RUN or DONE is ignored and is not queued.
REQ-024 cancel in RUN or DONE forces IDLE next cycle; done is not pulsed, hi/lo are unchanged, and cancel takes priority over a simultaneous start.
REQ-025 Overflow case (MIN / -1 signed) gives lo = MIN, hi = 0.

Reset
REQ-026 Asserting rst low forces IDLE, busy=0, stall=0, done=0, hi=0, lo=0 and counter=0, asynchronously and also mid-operation.
REQ-027 The first start after reset release is accepted on the first rising edge where rst is high.

Configuration
REQ-028 Macro MULDIV_FAST_MUL_EN: when defined, MULT/MULTU bypass RUN; IDLE->DONE occurs at the accept edge with a single-cycle combinational product, done is high 1 cycle after accept, and stall is low in that cycle.
REQ-029 Without MULDIV_FAST_MUL_EN, multiply uses the iterative path with WIDTH+1 latency; divide is iterative in both builds.

Structure
REQ-030 Shared package muldiv_pkg holds the op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), the FSM state enumeration and the state width.
REQ-031 Sub-module muldiv_abs performs operand sign-extraction/negation and result sign-restore and is instantiated twice (input and output); datapath registers and FSM are in muldiv_unit.

Verification
REQ-032 DIVU a=100, b=7 -> done at cycle 33 after accept; lo=14, hi=2; stall high cycles 0..32.
REQ-033 DIV a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
REQ-034 MULT a=0x80000000, b=0xFFFFFFFF -> hi=0x00000000, lo=0x80000000; MULTU of the same operands -> hi=0x7FFFFFFF, lo=0x80000000.
REQ-035 DIVU a=5, b=0 -> lo=0xFFFFFFFF, hi=5; DIV 0x80000000 / -1 -> lo=0x80000000, hi=0.
REQ-036 start DIVU, cancel at cycle 10, restart MULTU 3x4 at cycle 12 -> no done for the first op; second op gives hi=0, lo=12.
REQ-037 rst pulled low at cycle 5 of a DIV -> all outputs 0 immediately; with MULDIV_FAST_MUL_EN defined, MULTU 6x7 -> done 1 cycle after accept, lo=42.
